// File: rtl/park_gate_ctrl.sv
// Parking lot entry/exit gate controller: per-gate sensor debounce and barrier FSM,
// plus a saturating occupancy counter that refuses entry when the lot is full.

module park_gate #(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic pass_i,
  input  logic allow_i,
  output logic open_o,
  output logic deny_o,
  output logic commit_o
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OPEN, PASS} state_t;

  state_t            state_q;
  logic [DB_W-1:0]   db_q;
  logic [TM_W-1:0]   timer_q;
  logic              open_q, deny_q;
  logic              accept;

  // Counter saturates at DEBOUNCE so a held request fires exactly once.
  assign accept   = req_i && (db_q == DB_W'(DEBOUNCE - 1));
  assign commit_o = (state_q == PASS) && !pass_i;
  assign open_o   = open_q;
  assign deny_o   = deny_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                        db_q <= '0;
    else if (!req_i)                  db_q <= '0;
    else if (db_q != DB_W'(DEBOUNCE)) db_q <= db_q + DB_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      open_q  <= 1'b0;
      deny_q  <= 1'b0;
    end else begin
      deny_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (allow_i) begin
            state_q <= OPEN;
            timer_q <= TM_W'(TIMEOUT);
            open_q  <= 1'b1;
          end else begin
            deny_q  <= 1'b1;
          end
        end
        OPEN: begin
          if (pass_i) begin
            state_q <= PASS;
          end else if (timer_q == TM_W'(1)) begin
            state_q <= IDLE;
            open_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TM_W'(1);
          end
        end
        PASS: if (!pass_i) begin
          state_q <= IDLE;
          open_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          open_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

module park_gate_ctrl #(
  parameter int CAPACITY = 12,
  parameter int CNT_W    = 4,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             car_in_req_i,
  input  logic             pass_in_i,
  input  logic             car_out_req_i,
  input  logic             pass_out_i,
  output logic [CNT_W-1:0] count_o,
  output logic             gate_in_open_o,
  output logic             gate_out_open_o,
  output logic             denied_o,
  output logic             err_o
);
  localparam int NUM_GATES = 2;  // [0] entry, [1] exit

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic [NUM_GATES-1:0] req, pass, allow, open, deny, commit;

  assign req   = {car_out_req_i, car_in_req_i};
  assign pass  = {pass_out_i, pass_in_i};
  assign allow = {1'b1, (count_q < CNT_W'(CAPACITY))};

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    park_gate #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_gate (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req[g]),
      .pass_i   (pass[g]),
      .allow_i  (allow[g]),
      .open_o   (open[g]),
      .deny_o   (deny[g]),
      .commit_o (commit[g])
    );
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case (commit)
      2'b01: if (count_q < CNT_W'(CAPACITY)) count_d = count_q + CNT_W'(1);
      2'b10: begin
        if (count_q == '0) err_d   = 1'b1;
        else               count_d = count_q - CNT_W'(1);
      end
      default: ;  // simultaneous commits cancel
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o         = count_q;
  assign gate_in_open_o  = open[0];
  assign gate_out_open_o = open[1];
  assign denied_o        = |deny;  // exit gate is always allowed, never denies
  assign err_o           = err_q;
endmodule

// File: tb/tb_park_gate_ctrl.sv
// Directed bench for park_gate_ctrl: reset, entry flow, full lot, timeout,
// simultaneous commits and exit underflow.

module tb_park_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst, car_in_req, pass_in, car_out_req, pass_out;
  logic [3:0] count;
  logic       gate_in_open, gate_out_open, denied, err;
  int         n_cmp = 0, n_bad = 0;

  park_gate_ctrl #(.CAPACITY(12), .CNT_W(4), .DEBOUNCE(3), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .car_in_req_i(car_in_req), .pass_in_i(pass_in),
    .car_out_req_i(car_out_req), .pass_out_i(pass_out), .count_o(count),
    .gate_in_open_o(gate_in_open), .gate_out_open_o(gate_out_open),
    .denied_o(denied), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic entry_flow();
    car_in_req = 1'b1; tick(3);
    car_in_req = 1'b0; pass_in = 1'b1; tick();
    pass_in = 1'b0; tick();
  endtask

  task automatic exit_flow();
    car_out_req = 1'b1; tick(3);
    car_out_req = 1'b0; pass_out = 1'b1; tick();
    pass_out = 1'b0; tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; car_in_req = 0; pass_in = 0; car_out_req = 0; pass_out = 0;
    tick(2); rst = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (gate_in_open !== 1'b0) begin n_bad++; $display("FAIL rst_gin got=%b exp=0", gate_in_open); end
    n_cmp++; if (gate_out_open !== 1'b0) begin n_bad++; $display("FAIL rst_gout got=%b exp=0", gate_out_open); end
    n_cmp++; if (denied !== 1'b0) begin n_bad++; $display("FAIL rst_denied got=%b exp=0", denied); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    // Reset in the middle of activity: both gates open, one in PASS.
    car_in_req = 1; car_out_req = 1; tick(3);
    car_in_req = 0; car_out_req = 0; pass_in = 1; tick();
    n_cmp++; if ({gate_in_open, gate_out_open} !== 2'b11) begin n_bad++; $display("FAIL mid_open got=%b exp=11", {gate_in_open, gate_out_open}); end
    rst = 1; tick(2); rst = 0; pass_in = 0;
    n_cmp++; if ({gate_in_open, gate_out_open, count, err, denied} !== 8'd0) begin n_bad++;
      $display("FAIL mid_rst got=%b exp=0", {gate_in_open, gate_out_open, count, err, denied}); end
    tick();
    n_cmp++; if ({gate_in_open, count} !== 5'd0) begin n_bad++; $display("FAIL mid_rst_idle got=%b exp=0", {gate_in_open, count}); end
  endtask

  task automatic test_entry();
    car_in_req = 1; tick(2);
    n_cmp++; if (gate_in_open !== 1'b0) begin n_bad++; $display("FAIL ent_early got=%b exp=0", gate_in_open); end
    tick();
    n_cmp++; if (gate_in_open !== 1'b1) begin n_bad++; $display("FAIL ent_open got=%b exp=1", gate_in_open); end
    car_in_req = 0; pass_in = 1; tick(5);
    n_cmp++; if (gate_in_open !== 1'b1 || count !== 4'd0) begin n_bad++;
      $display("FAIL ent_pass got=%b/%0d exp=1/0", gate_in_open, count); end
    pass_in = 0; tick();
    n_cmp++; if (gate_in_open !== 1'b0) begin n_bad++; $display("FAIL ent_close got=%b exp=0", gate_in_open); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL ent_count got=%0d exp=1", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 11; i++) entry_flow();
    n_cmp++; if (count !== 4'd12) begin n_bad++; $display("FAIL full_count got=%0d exp=12", count); end
    car_in_req = 1; tick(3);
    n_cmp++; if (denied !== 1'b1 || gate_in_open !== 1'b0) begin n_bad++;
      $display("FAIL full_deny got=%b/%b exp=1/0", denied, gate_in_open); end
    tick();
    n_cmp++; if (denied !== 1'b0 || gate_in_open !== 1'b0) begin n_bad++;
      $display("FAIL full_pulse got=%b/%b exp=0/0", denied, gate_in_open); end
    car_in_req = 0; tick();
    n_cmp++; if (count !== 4'd12) begin n_bad++; $display("FAIL full_keep got=%0d exp=12", count); end
    exit_flow();
    n_cmp++; if (count !== 4'd11) begin n_bad++; $display("FAIL exit_count got=%0d exp=11", count); end
  endtask

  task automatic test_timeout();
    car_in_req = 1; tick(3); car_in_req = 0;
    n_cmp++; if (gate_in_open !== 1'b1) begin n_bad++; $display("FAIL to_open got=%b exp=1", gate_in_open); end
    tick(15);
    n_cmp++; if (gate_in_open !== 1'b1) begin n_bad++; $display("FAIL to_hold got=%b exp=1", gate_in_open); end
    tick();
    n_cmp++; if (gate_in_open !== 1'b0) begin n_bad++; $display("FAIL to_close got=%b exp=0", gate_in_open); end
    n_cmp++; if (count !== 4'd11) begin n_bad++; $display("FAIL to_count got=%0d exp=11", count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 5; i++) entry_flow();
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL sim_pre got=%0d exp=5", count); end
    car_in_req = 1; car_out_req = 1; tick(3);
    car_in_req = 0; car_out_req = 0;
    n_cmp++; if ({gate_in_open, gate_out_open} !== 2'b11) begin n_bad++; $display("FAIL sim_open got=%b exp=11", {gate_in_open, gate_out_open}); end
    pass_in = 1; pass_out = 1; tick();
    pass_in = 0; pass_out = 0; tick();
    n_cmp++; if (count !== 4'd5 || err !== 1'b0) begin n_bad++; $display("FAIL sim_commit got=%0d/%b exp=5/0", count, err); end
    n_cmp++; if ({gate_in_open, gate_out_open} !== 2'b00) begin n_bad++; $display("FAIL sim_close got=%b exp=00", {gate_in_open, gate_out_open}); end
  endtask

  task automatic test_underflow();
    do_reset();
    exit_flow();
    n_cmp++; if (count !== 4'd0 || err !== 1'b1) begin n_bad++; $display("FAIL uf_err got=%0d/%b exp=0/1", count, err); end
    entry_flow();
    n_cmp++; if (count !== 4'd1 || err !== 1'b1) begin n_bad++; $display("FAIL uf_sticky got=%0d/%b exp=1/1", count, err); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL uf_clear got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full();
    test_timeout();
    test_simultaneous();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
